// File: rtl/car_pkg.sv
// Shared types and helpers for the car start sequencer.
package car_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 3'd0,
    ST_CHECK   = 3'd1,
    ST_READY   = 3'd2,
    ST_FAULT   = 3'd3,
    ST_LOCKOUT = 3'd4
  } state_t;

  // Offsets of the seatbelt/airbag warn bits above the last sensor channel
  // (warn[NUM_SENS + WARN_SEATBELT], warn[NUM_SENS + WARN_AIRBAG]).
  localparam int unsigned WARN_SEATBELT = 0;
  localparam int unsigned WARN_AIRBAG   = 1;

  // Ceiling log2, never below 1 so the result can always size a vector.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    width = 0;
    while ((64'd1 << width) < 64'(value)) width++;
    return (width == 0) ? 1 : width;
  endfunction

endpackage

// File: rtl/car_sensor_window.sv
// Inclusive unsigned window comparator for one sensor channel.
// A window with lo > hi can never be satisfied, so the channel fails.
module car_sensor_window #(
  parameter int unsigned DATA_W = 16
) (
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  output logic              pass
);

  // Pass when lo <= data <= hi
  always_comb begin
    pass = (data >= lo) && (data <= hi);
  end

endmodule

// File: rtl/car_start_sequencer.sv
// Clocked start sequencer: PIN unlock with attempt counting and timed
// lockout, windowed sensor/seatbelt/airbag checks, and a settle period
// before readytogo. All outputs come straight from registers.
module car_start_sequencer
  import car_pkg::*;
#(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned NUM_SENS      = 7,
  parameter int unsigned PASSCODE      = 9999,
  parameter int unsigned MAX_ATTEMPTS  = 3,
  parameter int unsigned LOCKOUT_CYC   = 1000,
  parameter int unsigned SETTLE_CYC    = 4,
  parameter int unsigned CHECK_TIMEOUT = 256
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [DATA_W-1:0]                    pin,
  input  logic                                 pin_valid,
  input  logic                                 key_off,
  input  logic [NUM_SENS*DATA_W-1:0]           sens_data,
  input  logic [NUM_SENS*DATA_W-1:0]           lim_lo,
  input  logic [NUM_SENS*DATA_W-1:0]           lim_hi,
  input  logic                                 seatbelt,
  input  logic                                 airbag,
  output logic                                 key,
  output logic                                 readytogo,
  output logic [NUM_SENS+1:0]                  warn,
  output logic                                 locked_out,
  output logic [clog2(MAX_ATTEMPTS+1)-1:0]     attempts,
  output logic [STATE_W-1:0]                   state
);

  localparam int unsigned ATT_W = clog2(MAX_ATTEMPTS + 1);
  localparam int unsigned LCK_W = clog2(LOCKOUT_CYC);
  localparam int unsigned SET_W = clog2(SETTLE_CYC);
  localparam int unsigned TMO_W = clog2(CHECK_TIMEOUT);

  localparam logic [DATA_W-1:0] PASS_W   = DATA_W'(PASSCODE);
  localparam logic [ATT_W-1:0]  ATT_MAX  = ATT_W'(MAX_ATTEMPTS);
  localparam logic [ATT_W-1:0]  ATT_LAST = ATT_W'(MAX_ATTEMPTS - 1);
  localparam logic [LCK_W-1:0]  LCK_LOAD = LCK_W'(LOCKOUT_CYC - 1);
  localparam logic [SET_W-1:0]  SET_LAST = SET_W'(SETTLE_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(CHECK_TIMEOUT - 1);

  state_t             r_state, w_state_nxt;
  logic [ATT_W-1:0]   r_attempts, w_attempts_nxt;
  logic [LCK_W-1:0]   r_lock_tmr, w_lock_tmr_nxt;
  logic [SET_W-1:0]   r_settle, w_settle_nxt;
  logic [TMO_W-1:0]   r_tmo, w_tmo_nxt;

  logic               r_key;
  logic               r_ready;
  logic               r_locked;
  logic [NUM_SENS+1:0] r_warn;

  logic [NUM_SENS-1:0] w_chan_pass;
  logic [NUM_SENS+1:0] w_fail;
  logic                w_all_ok;
  logic                w_in_session;

  for (genvar g = 0; g < NUM_SENS; g++) begin : g_sens
    car_sensor_window #(
      .DATA_W (DATA_W)
    ) u_window (
      .data (sens_data[g*DATA_W +: DATA_W]),
      .lo   (lim_lo[g*DATA_W +: DATA_W]),
      .hi   (lim_hi[g*DATA_W +: DATA_W]),
      .pass (w_chan_pass[g])
    );
  end

  // Raw fail vector: one bit per failing check, sensors in the low bits
  always_comb begin
    w_fail                          = '0;
    w_fail[NUM_SENS-1:0]            = ~w_chan_pass;
    w_fail[NUM_SENS+WARN_SEATBELT]  = ~seatbelt;
    w_fail[NUM_SENS+WARN_AIRBAG]    = ~airbag;
    w_all_ok                        = ~|w_fail;
  end

  // Next state and counter updates; key_off wins over every session transition
  always_comb begin
    w_state_nxt    = r_state;
    w_attempts_nxt = r_attempts;
    w_lock_tmr_nxt = r_lock_tmr;
    w_settle_nxt   = r_settle;
    w_tmo_nxt      = r_tmo;
    case (r_state)
      ST_IDLE: begin
        if (pin_valid) begin
          if (pin == PASS_W) begin
            w_attempts_nxt = '0;
            w_settle_nxt   = '0;
            w_tmo_nxt      = '0;
            w_state_nxt    = ST_CHECK;
          end else if (r_attempts >= ATT_LAST) begin
            w_attempts_nxt = ATT_MAX;
            w_lock_tmr_nxt = LCK_LOAD;
            w_state_nxt    = ST_LOCKOUT;
          end else begin
            w_attempts_nxt = r_attempts + 1'b1;
          end
        end
      end
      ST_LOCKOUT: begin
        if (r_lock_tmr == '0) begin
          w_attempts_nxt = '0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_lock_tmr_nxt = r_lock_tmr - 1'b1;
        end
      end
      ST_CHECK: begin
        // The edge that completes the settle run moves straight to READY,
        // so readytogo appears SETTLE_CYC edges after entry; reaching READY
        // takes precedence over the timeout on the same edge.
        if (key_off) begin
          w_state_nxt = ST_IDLE;
        end else if (w_all_ok && (r_settle == SET_LAST)) begin
          w_state_nxt = ST_READY;
        end else if (r_tmo == TMO_LAST) begin
          w_state_nxt = ST_FAULT;
        end else begin
          w_tmo_nxt    = r_tmo + 1'b1;
          w_settle_nxt = w_all_ok ? (r_settle + 1'b1) : '0;
        end
      end
      ST_READY: begin
        if (key_off) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_all_ok) begin
          w_state_nxt = ST_FAULT;
        end
      end
      ST_FAULT: begin
        if (key_off) begin
          w_state_nxt = ST_IDLE;
        end else if (w_all_ok) begin
          w_settle_nxt = '0;
          w_tmo_nxt    = '0;
          w_state_nxt  = ST_CHECK;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    w_in_session = (w_state_nxt == ST_CHECK) || (w_state_nxt == ST_READY) ||
                   (w_state_nxt == ST_FAULT);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_attempts <= '0;
      r_lock_tmr <= '0;
      r_settle   <= '0;
      r_tmo      <= '0;
      r_key      <= 1'b0;
      r_ready    <= 1'b0;
      r_locked   <= 1'b0;
      r_warn     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_attempts <= w_attempts_nxt;
      r_lock_tmr <= w_lock_tmr_nxt;
      r_settle   <= w_settle_nxt;
      r_tmo      <= w_tmo_nxt;
      r_key      <= w_in_session;
      r_ready    <= (w_state_nxt == ST_READY);
      r_locked   <= (w_state_nxt == ST_LOCKOUT);
      r_warn     <= w_in_session ? w_fail : '0;
    end
  end

  assign key        = r_key;
  assign readytogo  = r_ready;
  assign warn       = r_warn;
  assign locked_out = r_locked;
  assign attempts   = r_attempts;
  assign state      = r_state;

endmodule

// File: tb/tb_car_start_sequencer.sv
// Self-checking bench for car_start_sequencer: directed sequences, a
// window-boundary vector table and randomized traffic against a model.
module tb_car_start_sequencer;

  localparam int unsigned DATA_W        = 16;
  localparam int unsigned NUM_SENS      = 7;
  localparam int unsigned PASSCODE      = 9999;
  localparam int unsigned MAX_ATTEMPTS  = 3;
  localparam int unsigned LOCKOUT_CYC   = 1000;
  localparam int unsigned SETTLE_CYC    = 4;
  localparam int unsigned CHECK_TIMEOUT = 256;

  localparam int S_IDLE = 0, S_CHECK = 1, S_READY = 2, S_FAULT = 3, S_LOCK = 4;

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [DATA_W-1:0]            pin = '0;
  logic                         pin_valid = 1'b0;
  logic                         key_off = 1'b0;
  logic                         seatbelt = 1'b1;
  logic                         airbag = 1'b1;
  logic [NUM_SENS*DATA_W-1:0]   sens_data, lim_lo, lim_hi;
  logic                         key, readytogo, locked_out;
  logic [NUM_SENS+1:0]          warn;
  logic [1:0]                   attempts;
  logic [2:0]                   state;

  logic [DATA_W-1:0] v_data [NUM_SENS];
  logic [DATA_W-1:0] v_lo   [NUM_SENS];
  logic [DATA_W-1:0] v_hi   [NUM_SENS];

  int checks = 0;
  int failures = 0;
  string phase = "init";

  // Model state (spec-level counts, not RTL counters)
  int m_st, m_att, m_left, m_run, m_chk;
  bit m_key, m_rdy, m_lock;
  logic [NUM_SENS+1:0] m_warn;

  typedef struct {
    int                  ch;
    logic [DATA_W-1:0]   val, lo, hi;
    bit                  sb, ab;
    logic [NUM_SENS+1:0] exp_warn;
  } vec_t;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NUM_SENS; g++) begin : g_pack
    assign sens_data[g*DATA_W +: DATA_W] = v_data[g];
    assign lim_lo[g*DATA_W +: DATA_W]    = v_lo[g];
    assign lim_hi[g*DATA_W +: DATA_W]    = v_hi[g];
  end

  car_start_sequencer #(
    .DATA_W        (DATA_W),
    .NUM_SENS      (NUM_SENS),
    .PASSCODE      (PASSCODE),
    .MAX_ATTEMPTS  (MAX_ATTEMPTS),
    .LOCKOUT_CYC   (LOCKOUT_CYC),
    .SETTLE_CYC    (SETTLE_CYC),
    .CHECK_TIMEOUT (CHECK_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pin        (pin),
    .pin_valid  (pin_valid),
    .key_off    (key_off),
    .sens_data  (sens_data),
    .lim_lo     (lim_lo),
    .lim_hi     (lim_hi),
    .seatbelt   (seatbelt),
    .airbag     (airbag),
    .key        (key),
    .readytogo  (readytogo),
    .warn       (warn),
    .locked_out (locked_out),
    .attempts   (attempts),
    .state      (state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [NUM_SENS+1:0] model_fail();
    logic [NUM_SENS+1:0] f;
    f = '0;
    for (int i = 0; i < NUM_SENS; i++)
      f[i] = !((int'(v_lo[i]) <= int'(v_data[i])) && (int'(v_data[i]) <= int'(v_hi[i])));
    f[NUM_SENS]   = !seatbelt;
    f[NUM_SENS+1] = !airbag;
    return f;
  endfunction

  task automatic model_reset();
    m_st = S_IDLE; m_att = 0; m_left = 0; m_run = 0; m_chk = 0;
    m_key = 0; m_rdy = 0; m_lock = 0; m_warn = '0;
  endtask

  // One clock edge of the reference behaviour
  task automatic model_step();
    logic [NUM_SENS+1:0] f;
    bit ok;
    int nxt;
    f   = model_fail();
    ok  = (f == '0);
    nxt = m_st;
    case (m_st)
      S_IDLE: if (pin_valid) begin
        if (int'(pin) == int'(PASSCODE)) begin
          m_att = 0; m_run = 0; m_chk = 0; nxt = S_CHECK;
        end else begin
          m_att++;
          if (m_att >= int'(MAX_ATTEMPTS)) begin
            nxt = S_LOCK; m_left = LOCKOUT_CYC;
          end
        end
      end
      S_LOCK: begin
        m_left--;
        if (m_left == 0) begin nxt = S_IDLE; m_att = 0; end
      end
      S_CHECK: if (key_off) nxt = S_IDLE;
      else begin
        m_run = ok ? m_run + 1 : 0;
        m_chk++;
        if (m_run == int'(SETTLE_CYC)) nxt = S_READY;
        else if (m_chk == int'(CHECK_TIMEOUT)) nxt = S_FAULT;
      end
      S_READY: if (key_off) nxt = S_IDLE; else if (!ok) nxt = S_FAULT;
      S_FAULT: if (key_off) nxt = S_IDLE;
      else if (ok) begin nxt = S_CHECK; m_run = 0; m_chk = 0; end
      default: nxt = S_IDLE;
    endcase
    m_st   = nxt;
    m_key  = (nxt >= S_CHECK) && (nxt <= S_FAULT);
    m_rdy  = (nxt == S_READY);
    m_lock = (nxt == S_LOCK);
    m_warn = m_key ? f : '0;
  endtask

  task automatic cmp_model();
    logic [16:0] a, e;
    a = {state, key, readytogo, locked_out, warn, (m_st == S_LOCK) ? 2'b00 : attempts};
    e = {3'(m_st), m_key, m_rdy, m_lock, m_warn, (m_st == S_LOCK) ? 2'b00 : 2'(m_att)};
    check(phase, 32'(a), 32'(e));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
    cmp_model();
  endtask

  task automatic set_sensors_default();
    for (int i = 0; i < NUM_SENS; i++) begin
      v_data[i] = 16'd150; v_lo[i] = 16'd100; v_hi[i] = 16'd200;
    end
    seatbelt = 1'b1; airbag = 1'b1;
  endtask

  task automatic enter_pin(input logic [DATA_W-1:0] p);
    pin = p; pin_valid = 1'b1;
    cycle();
    pin_valid = 1'b0;
  endtask

  task automatic go_idle();
    key_off = 1'b1;
    cycle();
    key_off = 1'b0;
  endtask

  task automatic async_reset(input string name);
    #3;
    rst = 1'b1;
    #1;
    check(name, 32'({state, key, readytogo, locked_out, warn, attempts}), 32'd0);
    model_reset();
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [11];
    int n;

    tbl[0]  = '{2, 16'd100, 16'd100, 16'd200, 1, 1, 9'h000};
    tbl[1]  = '{2, 16'd200, 16'd100, 16'd200, 1, 1, 9'h000};
    tbl[2]  = '{2, 16'd99,  16'd100, 16'd200, 1, 1, 9'h004};
    tbl[3]  = '{2, 16'd201, 16'd100, 16'd200, 1, 1, 9'h004};
    tbl[4]  = '{0, 16'd0,   16'd0,   16'd0,   1, 1, 9'h000};
    tbl[5]  = '{6, 16'hFFFF, 16'd0,  16'hFFFF, 1, 1, 9'h000};
    tbl[6]  = '{3, 16'd150, 16'd200, 16'd100, 1, 1, 9'h008};
    tbl[7]  = '{3, 16'd100, 16'd100, 16'd100, 1, 1, 9'h000};
    tbl[8]  = '{1, 16'd150, 16'd100, 16'd200, 0, 1, 9'h080};
    tbl[9]  = '{1, 16'd150, 16'd100, 16'd200, 1, 0, 9'h100};
    tbl[10] = '{5, 16'd0,   16'd1,   16'd200, 0, 0, 9'h1A0};

    set_sensors_default();
    model_reset();
    #7;
    phase = "reset";
    check("reset_state", 32'({state, key, readytogo, locked_out, warn, attempts}), 32'd0);
    rst = 1'b0;

    // Unlock and settle
    phase = "unlock";
    enter_pin(16'd9999);
    check("unlock_key", 32'(key), 32'd1);
    for (int i = 1; i <= int'(SETTLE_CYC); i++) begin
      cycle();
      check("settle_ready", 32'(readytogo), (i == int'(SETTLE_CYC)) ? 32'd1 : 32'd0);
    end
    check("ready_warn", 32'(warn), 32'd0);

    // Window boundary table
    phase = "table";
    for (int i = 0; i < 11; i++) begin
      set_sensors_default();
      v_data[tbl[i].ch] = tbl[i].val;
      v_lo[tbl[i].ch]   = tbl[i].lo;
      v_hi[tbl[i].ch]   = tbl[i].hi;
      seatbelt = tbl[i].sb;
      airbag   = tbl[i].ab;
      cycle();
      check($sformatf("tbl_warn_%0d", i), 32'(warn), 32'(tbl[i].exp_warn));
    end
    set_sensors_default();

    // Wrong PINs and lockout
    phase = "lockout";
    go_idle();
    enter_pin(16'd1234);
    check("attempts_1", 32'(attempts), 32'd1);
    enter_pin(16'd1234);
    check("attempts_2", 32'(attempts), 32'd2);
    enter_pin(16'd1234);
    check("lock_state", 32'(state), 32'd4);
    check("lock_flag", 32'(locked_out), 32'd1);
    n = 1;
    for (int i = 0; i < 1100; i++) begin
      if (i == 10) begin pin = 16'd9999; pin_valid = 1'b1; end
      cycle();
      pin_valid = 1'b0;
      if (!locked_out) break;
      n++;
    end
    check("lock_length", 32'(n), 32'(LOCKOUT_CYC));
    check("lock_exit_state", 32'(state), 32'd0);
    check("lock_exit_attempts", 32'(attempts), 32'd0);
    enter_pin(16'd9999);
    check("post_lock_key", 32'(key), 32'd1);

    // Channel failure in READY and recovery
    phase = "ready_fail";
    repeat (SETTLE_CYC) cycle();
    check("d_ready", 32'(readytogo), 32'd1);
    v_data[2] = 16'd201;
    cycle();
    check("d_drop_ready", 32'(readytogo), 32'd0);
    check("d_warn2", 32'(warn[2]), 32'd1);
    v_data[2] = 16'd150;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      n++;
      if (readytogo) break;
    end
    check("d_requalify", 32'(n), 32'(SETTLE_CYC + 1));

    // Seatbelt open for the whole check -> timeout
    phase = "timeout";
    go_idle();
    seatbelt = 1'b0;
    enter_pin(16'd9999);
    n = 0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      n++;
      if (state == 3'd3) break;
    end
    check("timeout_cycles", 32'(n), 32'(CHECK_TIMEOUT));
    check("timeout_warn_sb", 32'(warn[NUM_SENS]), 32'd1);

    // key_off together with a failure in READY
    phase = "keyoff";
    seatbelt = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (readytogo) break;
    end
    check("f_ready", 32'(readytogo), 32'd1);
    v_data[4] = 16'd0;
    key_off = 1'b1;
    cycle();
    key_off = 1'b0;
    v_data[4] = 16'd150;
    check("f_outputs", 32'({state, key, readytogo, warn}), 32'd0);

    // Asynchronous reset mid-CHECK and mid-LOCKOUT
    phase = "async_rst";
    enter_pin(16'd9999);
    repeat (2) cycle();
    async_reset("rst_mid_check");
    enter_pin(16'd9999);
    check("rst_check_unlock", 32'(key), 32'd1);
    go_idle();
    repeat (3) enter_pin(16'd4321);
    repeat (5) cycle();
    check("pre_rst_locked", 32'(locked_out), 32'd1);
    async_reset("rst_mid_lock");
    enter_pin(16'd9999);
    check("rst_lock_unlock", 32'(key), 32'd1);

    // Randomized traffic against the model
    phase = "random";
    for (int c = 0; c < 3000; c++) begin
      pin_valid = ($urandom_range(0, 7) == 0);
      pin       = ($urandom_range(0, 3) != 0) ? 16'd9999 : 16'($urandom);
      key_off   = ($urandom_range(0, 39) == 0);
      seatbelt  = ($urandom_range(0, 29) != 0);
      airbag    = ($urandom_range(0, 29) != 0);
      for (int i = 0; i < NUM_SENS; i++) begin
        if ($urandom_range(0, 49) == 0) begin
          v_lo[i] = 16'($urandom_range(0, 300));
          v_hi[i] = 16'($urandom_range(0, 300));
        end else begin
          v_lo[i] = 16'd100; v_hi[i] = 16'd200;
        end
        v_data[i] = ($urandom_range(0, 29) == 0) ? 16'($urandom_range(0, 300))
                                                 : 16'($urandom_range(100, 200));
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
